spec_mem_responder: RTL

- Memory-side responder for the formal spec harness. Observes the core's data bus across an instruction, logs up to two granule transactions (first/second), and answers the spec's memory read, tag and revocation queries from that log.
- Checks the spec's write requests against the core's logged writes.
- Sits between the core data-bus probes and the spec wrapper's mem_read/mem_write/mem_revoke ports; one instance per checked core.

---
 rtl/spec_mem_responder.sv | 204 ++++++++++++++++++++
 1 files changed

// File: rtl/spec_mem_responder.sv
// Memory-side responder for the formal spec harness: logs up to two granule transactions per instruction.
// Optional build macro SPEC_MEM_ERR_EN tracks bus errors per slot and adds the err_o port.
module spec_mem_responder #(
   parameter int MaxOutstanding = 2,
   parameter int LogDepth       = 2
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        data_req_i,
   input  logic        data_gnt_i,
   input  logic        data_we_i,
   input  logic [3:0]  data_be_i,
   input  logic [31:0] data_addr_i,
   input  logic [32:0] data_wdata_i,
   input  logic        data_rvalid_i,
   input  logic [32:0] data_rdata_i,
   input  logic        data_err_i,
   input  logic        rvk_valid_i,
   input  logic        rvk_bit_i,
   input  logic        retire_i,
   input  logic        flush_i,
   output logic        spec_valid_o,
   output logic [31:0] mem_read_fst_rdata_o,
   output logic [31:0] mem_read_snd_rdata_o,
   output logic        mem_read_tag_o,
   output logic        mem_revoke_o,
   input  logic        spec_mem_read_i,
   input  logic        spec_mem_read_snd_gran_i,
   input  logic [31:0] spec_mem_read_fst_addr_i,
   input  logic        spec_mem_write_i,
   input  logic        spec_mem_write_snd_gran_i,
   input  logic [31:0] spec_mem_write_fst_addr_i,
   input  logic [31:0] spec_mem_write_fst_wdata_i,
   input  logic [3:0]  spec_mem_write_fst_be_i,
   input  logic        spec_mem_write_tag_i,
   output logic        mismatch_o,
`ifdef SPEC_MEM_ERR_EN
   output logic        err_o,
`endif
   output logic        overflow_o
);

   localparam int CntW = $clog2(MaxOutstanding + 1);

   typedef struct packed {
      logic        we;
      logic [3:0]  be;
      logic [31:0] addr;
      logic [32:0] wdata;
   } req_t;

   typedef struct packed {
      logic        used;
      logic        err;
      logic        we;
      logic [3:0]  be;
      logic [31:0] addr;
      logic [31:0] data;
      logic        tag;
   } slot_t;

   typedef enum logic [1:0] {IDLE, COLLECT, DRAIN, SNAP} state_t;

   state_t          state_q, state_d;
   req_t            fifo_q [MaxOutstanding];
   logic [CntW-1:0] count_q, count_d, wr_idx;
   slot_t           log_q [LogDepth];
   slot_t           log_d [LogDepth];
   slot_t           new_slot;
   logic            rvk_q, rvk_d;
   logic            push, push_ok, pop_ok, comp_drop, resp_err;
   logic            rd_bad, wr_bad, none_bad, snap_next;
   logic            unused_write_snd;

   assign unused_write_snd = spec_mem_write_snd_gran_i;

`ifdef SPEC_MEM_ERR_EN
   assign resp_err = data_err_i;
`else
   logic unused_err;
   assign unused_err = data_err_i;
   assign resp_err   = 1'b0;
`endif

   function automatic logic [31:0] read_data(slot_t s);
      return (s.used && !s.we && !s.err) ? s.data : 32'h0;
   endfunction

   function automatic logic read_tag(slot_t s);
      return s.used && !s.we && !s.err && s.tag;
   endfunction

   // A push into a full FIFO is still accepted when the head pops in the same cycle.
   assign push      = data_req_i && data_gnt_i;
   assign pop_ok    = data_rvalid_i && (count_q != '0);
   assign push_ok   = push && ((count_q != CntW'(MaxOutstanding)) || pop_ok);
   assign count_d   = count_q + CntW'(push_ok) - CntW'(pop_ok);
   assign wr_idx    = pop_ok ? count_q - CntW'(1) : count_q;
   assign snap_next = (state_d == SNAP);

   always_comb begin
      new_slot      = '0;
      new_slot.used = 1'b1;
      new_slot.err  = resp_err;
      new_slot.we   = fifo_q[0].we;
      new_slot.be   = fifo_q[0].be;
      new_slot.addr = fifo_q[0].addr;
      new_slot.data = fifo_q[0].we ? fifo_q[0].wdata[31:0] : data_rdata_i[31:0];
      new_slot.tag  = fifo_q[0].we ? fifo_q[0].wdata[32]   : data_rdata_i[32];
   end

   always_comb begin
      log_d     = log_q;
      rvk_d     = rvk_q;
      comp_drop = 1'b0;
      if (pop_ok) begin
         if (!log_q[0].used)      log_d[0] = new_slot;
         else if (!log_q[1].used) log_d[1] = new_slot;
         else                     comp_drop = 1'b1;
      end
      if (rvk_valid_i) rvk_d = rvk_bit_i;
      if (state_q == SNAP || flush_i) begin
         for (int i = 0; i < LogDepth; i++) log_d[i] = '0;
         rvk_d = 1'b0;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: begin
            if (retire_i)     state_d = (count_d == '0) ? SNAP : DRAIN;
            else if (push_ok) state_d = COLLECT;
         end
         COLLECT: if (retire_i) state_d = (count_d == '0) ? SNAP : DRAIN;
         DRAIN:   if (count_d == '0) state_d = SNAP;
         SNAP:    state_d = (count_d != '0) ? COLLECT : IDLE;
      endcase
      if (flush_i && state_q != SNAP) state_d = (count_d != '0) ? COLLECT : IDLE;
   end

   // Errored slots are exempt; evaluated only while the snapshot is presented.
   always_comb begin
      rd_bad   = 1'b0;
      wr_bad   = 1'b0;
      none_bad = 1'b0;
      if (spec_mem_read_i) begin
         if (!log_q[0].err && (!log_q[0].used || log_q[0].we ||
             log_q[0].addr != spec_mem_read_fst_addr_i)) rd_bad = 1'b1;
         if (!log_q[1].err && (spec_mem_read_snd_gran_i != (log_q[1].used && !log_q[1].we)))
            rd_bad = 1'b1;
      end
      if (spec_mem_write_i && !log_q[0].err &&
          (!log_q[0].used || !log_q[0].we || log_q[0].addr != spec_mem_write_fst_addr_i ||
           log_q[0].data != spec_mem_write_fst_wdata_i || log_q[0].be != spec_mem_write_fst_be_i ||
           log_q[0].tag != spec_mem_write_tag_i)) wr_bad = 1'b1;
      if (!spec_mem_read_i && !spec_mem_write_i && (log_q[0].used || log_q[1].used))
         none_bad = 1'b1;
   end

   always_ff @(posedge clk_i) begin
      for (int i = 0; i < MaxOutstanding - 1; i++)
         if (pop_ok) fifo_q[i] <= fifo_q[i + 1];
      for (int i = 0; i < MaxOutstanding; i++)
         if (push_ok && wr_idx == CntW'(i))
            fifo_q[i] <= '{we: data_we_i, be: data_be_i, addr: data_addr_i, wdata: data_wdata_i};
   end

   // Snapshot outputs are registered from the next-cycle log so they line up with SNAP.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q              <= IDLE;
         count_q              <= '0;
         rvk_q                <= 1'b0;
         for (int i = 0; i < LogDepth; i++) log_q[i] <= '0;
         spec_valid_o         <= 1'b0;
         mem_read_fst_rdata_o <= '0;
         mem_read_snd_rdata_o <= '0;
         mem_read_tag_o       <= 1'b0;
         mem_revoke_o         <= 1'b0;
         mismatch_o           <= 1'b0;
         overflow_o           <= 1'b0;
`ifdef SPEC_MEM_ERR_EN
         err_o                <= 1'b0;
`endif
      end else begin
         state_q              <= state_d;
         count_q              <= count_d;
         rvk_q                <= rvk_d;
         log_q                <= log_d;
         spec_valid_o         <= snap_next;
         mem_read_fst_rdata_o <= snap_next ? read_data(log_d[0]) : '0;
         mem_read_snd_rdata_o <= snap_next ? read_data(log_d[1]) : '0;
         mem_read_tag_o       <= snap_next && read_tag(log_d[0]);
         mem_revoke_o         <= snap_next && rvk_d;
         if (state_q == SNAP) mismatch_o <= rd_bad || wr_bad || none_bad;
         if ((push && !push_ok) || (data_rvalid_i && !pop_ok) || comp_drop) overflow_o <= 1'b1;
`ifdef SPEC_MEM_ERR_EN
         err_o <= snap_next && ((log_d[0].used && log_d[0].err) || (log_d[1].used && log_d[1].err));
`endif
      end
   end

endmodule
